// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch (IF) and data (DM) requesters.
// Defining ARB_STATS_EN adds saturating grant and fetch-stall counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_if_grants,
  output logic [15:0]       stat_dm_grants,
  output logic [15:0]       stat_if_stall
`endif
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int CNT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic [CNT_W-1:0]    WAIT_LOAD  = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  logic                owner_dm;
  logic                we_lat;
  logic [STREAK_W-1:0] streak;
  logic [CNT_W-1:0]    wait_cnt;
  logic                grant;
  logic                pick_dm;

  // The ready pulse cycle is spent in IDLE; requests are not sampled until it has passed,
  // so a requester that drops req right after its pulse is not granted twice.
  assign grant   = (state == IDLE) && !if_ready && !dm_ready && (if_req || dm_req);
  assign pick_dm = dm_req && !(if_req && (streak == STREAK_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      we_lat    <= 1'b0;
      streak    <= '0;
      wait_cnt  <= '0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_rdata  <= '0;
      dm_ready  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner_dm  <= pick_dm;
            we_lat    <= pick_dm && dm_we;
            mem_en    <= 1'b1;
            mem_we    <= pick_dm && dm_we;
            mem_addr  <= pick_dm ? dm_addr : if_addr;
            mem_wdata <= pick_dm ? dm_wdata : '0;
            busy      <= 1'b1;
            state     <= ISSUE;
            if (pick_dm && if_req) streak <= streak + 1'b1;
            else                   streak <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          if (MEM_LAT > 1) begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end else begin
            state <= RESP;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= RESP;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        RESP: begin
          // mem_rdata is valid in this cycle; the pulse appears in the following one.
          if (owner_dm) begin
            dm_ready <= 1'b1;
            dm_rdata <= we_lat ? '0 : mem_rdata;
          end else begin
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic if_grant;
  logic dm_grant;
  logic if_active;

  assign if_grant  = grant && !pick_dm;
  assign dm_grant  = grant && pick_dm;
  assign if_active = ((state != IDLE) && !owner_dm) || if_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_if_grants <= '0;
      stat_dm_grants <= '0;
      stat_if_stall  <= '0;
    end else begin
      if (if_grant && (stat_if_grants != 16'hFFFF)) stat_if_grants <= stat_if_grants + 16'd1;
      if (dm_grant && (stat_dm_grants != 16'hFFFF)) stat_dm_grants <= stat_dm_grants + 16'd1;
      if (if_req && !if_grant && !if_active && (stat_if_stall != 16'hFFFF))
        stat_if_stall <= stat_if_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts every output each cycle,
// and a set of pinned literal expectations anchors the model on the key scenarios.
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  localparam int MS  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_en, mem_we, busy;
`ifdef ARB_STATS_EN
  logic [15:0] stat_if_grants, stat_dm_grants, stat_if_stall;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_STREAK(MS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_dm_grants(stat_dm_grants), .stat_if_stall(stat_if_stall)
`endif
  );

  function automatic logic [31:0] seed_word(int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 0) ? 32'hDEADBEEF : {b, b, b, b};
  endfunction

  // Memory device: read data valid exactly LAT cycles after mem_en, random garbage otherwise.
  logic [31:0] dev_mem [16];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (mem_en && !mem_we) ? dev_mem[mem_addr[5:2]] : $urandom;
    if (reset) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= seed_word(i);
    end else if (mem_en && mem_we) begin
      dev_mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Transaction-level model state
  int          free_at, iss_at, rdy_at, streak, if_rel, dm_rel;
  bit          own_dm, own_we, if_gr, dm_gr, hold_mode;
  logic [31:0] own_addr, own_wdata, own_data, exp_if_rdata, exp_dm_rdata;
  logic [31:0] ref_mem [16];

  typedef struct { int at; int sig; logic [31:0] val; } pin_t;
  pin_t pins[$];
  localparam int S_EN = 0, S_WE = 1, S_ADDR = 2, S_WDATA = 3, S_IFRDY = 4, S_IFDAT = 5,
                 S_DMRDY = 6, S_DMDAT = 7, S_BUSY = 8;

  function automatic logic [31:0] sig_val(int s);
    case (s)
      S_EN:    return 32'(mem_en);
      S_WE:    return 32'(mem_we);
      S_ADDR:  return mem_addr;
      S_WDATA: return mem_wdata;
      S_IFRDY: return 32'(if_ready);
      S_IFDAT: return if_rdata;
      S_DMRDY: return 32'(dm_ready);
      S_DMDAT: return dm_rdata;
      default: return 32'(busy);
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, want);
    end
  endtask

  task automatic pin(int at, int sig, logic [31:0] val);
    pins.push_back('{at, sig, val});
  endtask

  task automatic model_reset();
    iss_at = -100; rdy_at = -100; streak = 0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    if_rel = -1; dm_rel = -1; if_gr = 0; dm_gr = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = seed_word(i);
  endtask

  // Consumes this cycle's inputs: reset, or an arbitration when the port is free.
  task automatic model_update();
    bit pick;
    if (reset) begin
      model_reset();
      free_at = cyc + 1;
    end else if (cyc >= free_at && (if_req || dm_req)) begin
      pick = dm_req && !(if_req && streak == MS);
      streak = (pick && if_req) ? streak + 1 : 0;
      own_dm = pick;
      own_we = pick && dm_we;
      own_addr = pick ? dm_addr : if_addr;
      own_wdata = dm_wdata;
      if (own_we) begin
        ref_mem[own_addr[5:2]] = own_wdata;
        own_data = '0;
      end else begin
        own_data = ref_mem[own_addr[5:2]];
      end
      iss_at = cyc + 1;
      rdy_at = cyc + LAT + 2;
      free_at = cyc + LAT + 3;
      if (!hold_mode) begin
        if (pick) begin dm_rel = rdy_at + 1; dm_gr = 1; end
        else      begin if_rel = rdy_at + 1; if_gr = 1; end
      end
    end
  endtask

  task automatic check_cycle();
    bit iss, rdy;
    iss = (cyc == iss_at);
    rdy = (cyc == rdy_at);
    if (rdy && !own_dm) exp_if_rdata = own_data;
    if (rdy && own_dm)  exp_dm_rdata = own_data;
    chk("mem_en", 32'(mem_en), 32'(iss));
    chk("mem_we", 32'(mem_we), 32'(iss && own_we));
    if (iss) chk("mem_addr", mem_addr, own_addr);
    if (iss && own_we) chk("mem_wdata", mem_wdata, own_wdata);
    chk("if_ready", 32'(if_ready), 32'(rdy && !own_dm));
    chk("dm_ready", 32'(dm_ready), 32'(rdy && own_dm));
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("dm_rdata", dm_rdata, exp_dm_rdata);
    chk("busy", 32'(busy), 32'(cyc >= iss_at && cyc <= rdy_at));
    foreach (pins[i]) if (pins[i].at == cyc) chk($sformatf("pin%0d", pins[i].sig), sig_val(pins[i].sig), pins[i].val);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    if (cyc == if_rel) begin if_req = 0; if_gr = 0; end
    if (cyc == dm_rel) begin dm_req = 0; dm_gr = 0; end
    // Address/data changes after a grant must not reach the memory.
    if (if_gr) if_addr = $urandom;
    if (dm_gr) begin dm_addr = $urandom; dm_wdata = $urandom; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cyc < free_at || if_req || dm_req) && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL wait_idle timeout at cycle %0d", cyc);
    end
  endtask

  initial begin
    int c0;
    reset = 1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    hold_mode = 0; free_at = 0; own_dm = 0; own_we = 0;
    own_addr = '0; own_wdata = '0; own_data = '0;
    model_reset();
    tick(); tick();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_ready", 32'(dm_ready), 0);
    reset = 0;

    // Single fetch
    wait_idle(); c0 = cyc;
    if_req = 1; if_addr = 32'h100;
    pin(c0 + 1, S_EN, 1); pin(c0 + 1, S_ADDR, 32'h100); pin(c0 + 1, S_WE, 0);
    pin(c0 + 2, S_EN, 0); pin(c0 + 3, S_EN, 0);
    pin(c0 + 5, S_IFRDY, 1); pin(c0 + 5, S_IFDAT, 32'hDEADBEEF); pin(c0 + 6, S_BUSY, 0);
    wait_idle();

    // Simultaneous requests: DM first, IF in the next IDLE
    c0 = cyc;
    dm_req = 1; dm_we = 0; dm_addr = 32'h200; if_req = 1; if_addr = 32'h104;
    pin(c0 + 1, S_ADDR, 32'h200); pin(c0 + LAT + 4, S_EN, 1); pin(c0 + LAT + 4, S_ADDR, 32'h104);
    pin(c0 + LAT + 2, S_DMRDY, 1); pin(c0 + LAT + 2, S_DMDAT, 32'hDEADBEEF);
    wait_idle();

    // Both held: four DM grants then one IF grant, twice
    c0 = cyc; hold_mode = 1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h80; if_req = 1; if_addr = 32'h1C0;
    for (int k = 0; k < 10; k++)
      pin(c0 + 1 + k * (LAT + 3), S_ADDR, (k % 5 == 4) ? 32'h1C0 : 32'h80);
    while (cyc < c0 + 9 * (LAT + 3) + 1) tick();
    if_req = 0; dm_req = 0; hold_mode = 0;
    wait_idle();

    // DM write
    c0 = cyc;
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
    pin(c0 + 1, S_EN, 1); pin(c0 + 1, S_WE, 1); pin(c0 + 1, S_ADDR, 32'h40);
    pin(c0 + 1, S_WDATA, 32'h12345678); pin(c0 + 5, S_DMRDY, 1); pin(c0 + 5, S_DMDAT, 0);
    wait_idle();

    // Reset in the middle of a read
    c0 = cyc;
    if_req = 1; if_addr = 32'h300;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0; if_req = 0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_mem_en", 32'(mem_en), 0);
    chk("midrst_if_rdata", if_rdata, 0);
`ifdef ARB_STATS_EN
    chk("midrst_stats", {stat_if_grants, stat_dm_grants} | 32'(stat_if_stall), 0);
`endif
    tick();
    if_req = 1; if_addr = 32'h104;
    pin(c0 + 5, S_IFRDY, 0); pin(c0 + 5, S_EN, 1); pin(c0 + 5, S_ADDR, 32'h104);
    pin(c0 + 9, S_IFRDY, 1); pin(c0 + 9, S_IFDAT, 32'h01010101);
    wait_idle();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if (!if_req && cyc > if_rel && $urandom_range(0, 3) != 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (!dm_req && cyc > dm_rel && $urandom_range(0, 3) != 0) begin
        dm_req = 1; dm_we = $urandom_range(0, 1) == 1; dm_addr = $urandom; dm_wdata = $urandom;
      end
      tick();
    end
    if_req = 0; dm_req = 0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
